// File: rtl/mult_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_pkg
// Brief    : Shared op encodings, state enumeration and default sizes for the
//            iterative signed multiplier/divider.
// Revision : 1.0 - initial release
// ============================================================================
package mult_div_pkg;

   localparam int WIDTH = 32;
   localparam int ITER  = 32;
   localparam int CNT_W = 6;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/mult_div.sv
`default_nettype none
// ============================================================================
// Module   : mult_div
// Brief    : Iterative signed multiply (radix-2 Booth) and signed restoring
//            divide sharing one WIDTH+1 bit add/subtract datapath.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div #(
   parameter int WIDTH = mult_div_pkg::WIDTH,
   parameter int ITER  = mult_div_pkg::ITER
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   import mult_div_pkg::*;

   state_t               state_q, state_d;
   logic                 op_q;
   logic [WIDTH:0]       acc_q;
   logic [WIDTH-1:0]     qr_q;
   logic                 qm1_q;
   logic [WIDTH-1:0]     mcand_q;
   logic                 neg_quo_q;
   logic                 neg_rem_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [WIDTH-1:0]     hi_q, lo_q;
   logic                 div_zero_q;

   logic                 accept;
   logic                 div0;
   logic                 last_iter;
   logic [WIDTH-1:0]     a_mag, b_mag;

   logic [WIDTH:0]       add_x, add_y, add_sum;
   logic                 add_sub;
   logic [WIDTH:0]       booth_sel;
   logic [WIDTH:0]       acc_step;
   logic [WIDTH-1:0]     qr_step;
   logic                 qm1_step;
   logic [WIDTH-1:0]     res_hi, res_lo;

   assign accept    = (state_q == ST_IDLE) && start;
   assign div0      = (op == OP_DIV) && (b == '0);
   assign last_iter = (state_q == ST_RUN) && (cnt_q == CNT_W'(ITER - 1));
   assign a_mag     = a[WIDTH-1] ? ('0 - a) : a;
   assign b_mag     = b[WIDTH-1] ? ('0 - b) : b;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = div0 ? ST_FINISH : ST_RUN;
            end
         end
         ST_RUN: begin
            if (last_iter) begin
               state_d = ST_FINISH;
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy = (state_q != ST_IDLE);
      done = (state_q == ST_FINISH);
   end

   // Shared adder: Booth adds/subtracts the sign-extended multiplicand;
   // division always subtracts the divisor magnitude from the shifted remainder.
   always_comb begin
      add_x   = acc_q;
      add_y   = {mcand_q[WIDTH-1], mcand_q};
      add_sub = qr_q[0] & ~qm1_q;
      if (op_q == OP_DIV) begin
         add_x   = {acc_q[WIDTH-1:0], qr_q[WIDTH-1]};
         add_y   = {1'b0, mcand_q};
         add_sub = 1'b1;
      end
      add_sum = add_x + (add_y ^ {(WIDTH+1){add_sub}}) + {{WIDTH{1'b0}}, add_sub};
   end

   always_comb begin
      booth_sel = acc_q;
      acc_step  = acc_q;
      qr_step   = qr_q;
      qm1_step  = qm1_q;
      if (op_q == OP_MULT) begin
         booth_sel = (qr_q[0] ^ qm1_q) ? add_sum : acc_q;
         acc_step  = {booth_sel[WIDTH], booth_sel[WIDTH:1]};
         qr_step   = {booth_sel[0], qr_q[WIDTH-1:1]};
         qm1_step  = qr_q[0];
      end else if (!add_sum[WIDTH]) begin
         acc_step = add_sum;
         qr_step  = {qr_q[WIDTH-2:0], 1'b1};
      end else begin
         acc_step = add_x;
         qr_step  = {qr_q[WIDTH-2:0], 1'b0};
      end
   end

   // Final result straight from the last step so hi/lo change only with done.
   always_comb begin
      res_hi = acc_step[WIDTH-1:0];
      res_lo = qr_step;
      if (op_q == OP_DIV) begin
         res_hi = neg_rem_q ? ('0 - acc_step[WIDTH-1:0]) : acc_step[WIDTH-1:0];
         res_lo = neg_quo_q ? ('0 - qr_step) : qr_step;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q       <= OP_MULT;
         acc_q      <= '0;
         qr_q       <= '0;
         qm1_q      <= 1'b0;
         mcand_q    <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         cnt_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         div_zero_q <= 1'b0;
      end else if (accept) begin
         op_q       <= op;
         acc_q      <= '0;
         qm1_q      <= 1'b0;
         cnt_q      <= '0;
         div_zero_q <= div0;
         neg_quo_q  <= a[WIDTH-1] ^ b[WIDTH-1];
         neg_rem_q  <= a[WIDTH-1];
         if (op == OP_DIV) begin
            qr_q    <= a_mag;
            mcand_q <= b_mag;
         end else begin
            qr_q    <= a;
            mcand_q <= b;
         end
      end else if (state_q == ST_RUN) begin
         acc_q <= acc_step;
         qr_q  <= qr_step;
         qm1_q <= qm1_step;
         if (last_iter) begin
            cnt_q <= '0;
            hi_q  <= res_hi;
            lo_q  <= res_lo;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign hi       = hi_q;
   assign lo       = lo_q;
   assign div_zero = div_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div
// Brief    : Scoreboard bench for mult_div: directed cases plus random ops
//            checked against plain signed 64-bit arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div;
   import mult_div_pkg::*;

   localparam int W    = 32;
   localparam int N_IT = 32;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      logic         keep;
      int           due;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset, start, op;
   logic [W-1:0] a, b;
   logic         busy, done, div_zero;
   logic [W-1:0] hi, lo;

   exp_t         sb_q[$];
   exp_t         mon_e;
   int           ecnt = 0;
   int           n_chk = 0;
   int           n_pass = 0;
   logic [W-1:0] held_hi = '0;
   logic [W-1:0] held_lo = '0;
   logic         held_dz = 1'b0;
   logic         mon_en = 1'b0;
   logic         prev_done = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) ecnt <= ecnt + 1;

   mult_div #(.WIDTH(W), .ITER(N_IT)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
   endtask

   // Reference: exact signed arithmetic on 64-bit integers.
   function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  input int acc_edge);
      exp_t   e;
      longint sx, sy, p, q, r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      e.hi = '0; e.lo = '0; e.dz = 1'b0; e.keep = 1'b0; e.due = acc_edge + N_IT;
      if (o == OP_MULT) begin
         p = sx * sy;
         e.hi = p[63:32];
         e.lo = p[31:0];
      end else if (y == '0) begin
         e.keep = 1'b1;
         e.dz   = 1'b1;
         e.due  = acc_edge;
      end else begin
         q = sx / sy;
         r = sx % sy;
         e.hi = r[31:0];
         e.lo = q[31:0];
      end
      return e;
   endfunction

   // Monitor: pops the scoreboard on done, otherwise hi/lo must hold.
   always @(negedge clk) begin
      if (mon_en && !reset) begin
         if (prev_done) chk("done_one_cycle", done, 0);
         if (done) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_done", done, 0);
            end else begin
               mon_e = sb_q.pop_front();
               if (mon_e.keep) begin
                  mon_e.hi = held_hi;
                  mon_e.lo = held_lo;
               end
               chk("done_cycle", ecnt, mon_e.due);
               chk("hi", hi, mon_e.hi);
               chk("lo", lo, mon_e.lo);
               chk("div_zero", div_zero, mon_e.dz);
               chk("busy_at_done", busy, 1);
               held_hi = mon_e.hi;
               held_lo = mon_e.lo;
               held_dz = mon_e.dz;
            end
         end else begin
            chk("hold_hi", hi, held_hi);
            chk("hold_lo", lo, held_lo);
         end
         prev_done = done;
      end else begin
         prev_done = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         step();
         n++;
      end
      chk("idle_wait", busy, 0);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 64) begin
         step();
         n++;
      end
      chk("done_wait", done, 1);
   endtask

   // Issues one op; returns in cycle T+1 with inputs scrambled.
   task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t e;
      wait_idle();
      chk("dz_hold", div_zero, held_dz);
      start = 1'b1; op = o; a = x; b = y;
      step();
      start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
      e = model(o, x, y, ecnt);
      sb_q.push_back(e);
      chk("busy_T1", busy, 1);
      chk("dz_T1", div_zero, e.dz);
   endtask

   task automatic chk_res(input string nm, input logic [W-1:0] h, input logic [W-1:0] l);
      chk({nm, "_hi"}, hi, h);
      chk({nm, "_lo"}, lo, l);
   endtask

   initial begin
      logic         seen;
      logic         ro;
      logic [W-1:0] ra, rb;
      int           sel;

      reset = 1'b1; start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd7;
      repeat (3) step();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dz", div_zero, 0);
      chk_res("rst", '0, '0);
      reset = 1'b0; start = 1'b0;
      mon_en = 1'b1;

      issue(OP_MULT, 32'd7, 32'hFFFF_FFFD);
      wait_done();
      chk_res("mul_7x-3", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

      issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
      wait_done();
      chk_res("mul_min_sq", 32'h4000_0000, 32'h0000_0000);

      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done();
      chk_res("div_-7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      chk("div_-7/2_dz", div_zero, 0);

      // 1628201331 * 805654952 = 0x12345678_12345678
      issue(OP_MULT, 32'd1628201331, 32'd805654952);
      wait_done();
      chk_res("preload", 32'h1234_5678, 32'h1234_5678);
      issue(OP_DIV, 32'd5, 32'd0);
      chk("div0_done_T1", done, 1);
      chk("div0_flag_T1", div_zero, 1);
      chk_res("div0_keep", 32'h1234_5678, 32'h1234_5678);

      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done();
      chk_res("div_min/-1", 32'h0000_0000, 32'h8000_0000);
      chk("div_min/-1_dz", div_zero, 0);

      // Start pulse at T+5 must be ignored.
      issue(OP_MULT, 32'h0001_2345, 32'hFFFF_0F0F);
      repeat (4) step();
      start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd0;
      step();
      start = 1'b0;
      wait_done();

      // Start offered only in the FINISH cycle must be dropped.
      issue(OP_MULT, 32'd12345, 32'd678);
      wait_done();
      start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd3;
      step();
      start = 1'b0;
      chk("finish_ignore_1", busy, 0);
      step();
      chk("finish_ignore_2", busy, 0);

      // Reset at T+10 aborts the operation.
      issue(OP_MULT, 32'hDEAD_BEEF, 32'h0BAD_F00D);
      repeat (9) step();
      reset = 1'b1;
      step();
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk_res("abort", '0, '0);
      reset = 1'b0;
      sb_q.delete();
      held_hi = '0; held_lo = '0; held_dz = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         step();
         seen = seen | done;
      end
      chk("abort_no_done", seen, 0);

      for (int i = 0; i < 150; i++) begin
         ro  = 1'($urandom);
         ra  = $urandom;
         rb  = $urandom;
         sel = int'($urandom_range(0, 7));
         if (sel == 0) rb = '0;
         if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
         if (sel == 2) rb = 32'($urandom_range(1, 9));
         issue(ro, ra, rb);
      end
      wait_idle();
      repeat (3) step();
      chk("scoreboard_empty", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
